// File: rtl/dafa_exec_ctrl_if.sv
// dafa_exec_ctrl_if
// Command/response handshake bundle for the DAFA execution control stage.
//   cmd_valid / cmd_ready : command handshake (accept = both high at a rising edge)
//   cmd_op                : 00 LOAD, 01 ADD, 10 UNDO, 11 CLEAR
//   cmd_x / cmd_y         : operands (cmd_x doubles as the LOAD value)
//   rsp_valid / rsp_err   : one-cycle completion pulse and its error qualifier
// The master modport is the command issuer; the slave modport is the control stage.
interface dafa_exec_ctrl_if #(
   parameter int WIDTH = 12
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_x;
   logic [WIDTH-1:0] cmd_y;
   logic             rsp_valid;
   logic             rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_x, cmd_y,
      input  cmd_ready, rsp_valid, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_x, cmd_y,
      output cmd_ready, rsp_valid, rsp_err
   );
endinterface

// File: rtl/dafa_exec_ctrl.sv
// dafa_exec_ctrl
// Sequential control stage around the 12-bit reversible adder (DAFA). Holds the
// accumulator and overflow flag, drives the adder inputs from registers, waits a
// fixed settle window, then commits the adder result. A LIFO of previous
// accumulator states provides undo, and the adder's y output is checked against
// the registered y to confirm the adder left it untouched.
// Ports:
//   clk, rst      : rising-edge clock, asynchronous active-high reset
//   bus           : command/response handshake (slave side)
//   add_*_o       : registered operands to the adder (s, x, y, ovf)
//   add_*_i       : adder results (s, y, ovf), sampled only at the commit edge
//   acc_s/acc_ovf : accumulator and overflow flag
//   hist_count    : number of valid history entries
module dafa_exec_ctrl #(
   parameter  int WIDTH  = 12,
   parameter  int DEPTH  = 8,
   parameter  int SETTLE = 2,
   localparam int HW     = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   dafa_exec_ctrl_if.slave      bus,
   output logic [WIDTH-1:0]     add_s_o,
   output logic [WIDTH-1:0]     add_x_o,
   output logic [WIDTH-1:0]     add_y_o,
   output logic                 add_ovf_o,
   input  logic [WIDTH-1:0]     add_s_i,
   input  logic [WIDTH-1:0]     add_y_i,
   input  logic                 add_ovf_i,
   output logic [WIDTH-1:0]     acc_s,
   output logic                 acc_ovf,
   output logic [HW-1:0]        hist_count
);

   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_ADD   = 2'b01;
   localparam logic [1:0] OP_UNDO  = 2'b10;
   localparam logic [1:0] OP_CLEAR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_COMMIT
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] acc_s_q, acc_s_d;
   logic             acc_ovf_q, acc_ovf_d;
   logic [HW-1:0]    hist_count_q, hist_count_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_err_q, rsp_err_d;

   // History storage: entry = {ovf, s}. Storage needs no reset since
   // hist_count_q alone decides which entries are meaningful.
   logic [WIDTH:0]   hist_mem_q [DEPTH];
   logic             push;
   logic [AW-1:0]    push_idx;
   logic [AW-1:0]    pop_idx;
   logic [WIDTH:0]   pop_data;
   logic             hist_full;
   logic             accept;

   assign hist_full = (hist_count_q == HW'(DEPTH));
   assign accept    = bus.cmd_valid && (state_q == ST_IDLE);
   assign push_idx  = hist_count_q[AW-1:0];
   assign pop_idx   = AW'(hist_count_q - HW'(1));
   assign pop_data  = hist_mem_q[pop_idx];

   // Next-state and datapath decisions. Every command response is registered,
   // so rsp_valid lands one cycle after the deciding edge and is a single pulse.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      x_d          = x_q;
      y_d          = y_q;
      acc_s_d      = acc_s_q;
      acc_ovf_d    = acc_ovf_q;
      hist_count_d = hist_count_q;
      rsp_valid_d  = 1'b0;
      rsp_err_d    = 1'b0;
      push         = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               unique case (bus.cmd_op)
                  OP_LOAD: begin
                     rsp_valid_d = 1'b1;
                     if (hist_full) begin
                        rsp_err_d = 1'b1;
                     end else begin
                        push         = 1'b1;
                        hist_count_d = hist_count_q + HW'(1);
                        acc_s_d      = bus.cmd_x;
                        acc_ovf_d    = 1'b0;
                     end
                  end
                  OP_ADD: begin
                     // A full history means the result could not be undone,
                     // so the add is refused up front without running it.
                     if (hist_full) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                     end else begin
                        x_d     = bus.cmd_x;
                        y_d     = bus.cmd_y;
                        cnt_d   = CW'(SETTLE - 1);
                        state_d = ST_SETTLE;
                     end
                  end
                  OP_UNDO: begin
                     rsp_valid_d = 1'b1;
                     if (hist_count_q == '0) begin
                        rsp_err_d = 1'b1;
                     end else begin
                        hist_count_d = hist_count_q - HW'(1);
                        acc_s_d      = pop_data[WIDTH-1:0];
                        acc_ovf_d    = pop_data[WIDTH];
                     end
                  end
                  OP_CLEAR: begin
                     rsp_valid_d  = 1'b1;
                     acc_s_d      = '0;
                     acc_ovf_d    = 1'b0;
                     hist_count_d = '0;
                  end
                  default: ;
               endcase
            end
         end

         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = ST_COMMIT;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end

         ST_COMMIT: begin
            // A reversible adder must hand y back unchanged; anything else means
            // the result is not trustworthy and is discarded.
            rsp_valid_d = 1'b1;
            state_d     = ST_IDLE;
            if (add_y_i == y_q) begin
               push         = 1'b1;
               hist_count_d = hist_count_q + HW'(1);
               acc_s_d      = add_s_i;
               acc_ovf_d    = add_ovf_i;
            end else begin
               rsp_err_d = 1'b1;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any in-flight add.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         x_q          <= '0;
         y_q          <= '0;
         acc_s_q      <= '0;
         acc_ovf_q    <= 1'b0;
         hist_count_q <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         x_q          <= x_d;
         y_q          <= y_d;
         acc_s_q      <= acc_s_d;
         acc_ovf_q    <= acc_ovf_d;
         hist_count_q <= hist_count_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   // Push always captures the accumulator value from before the update.
   always_ff @(posedge clk) begin
      if (push) begin
         hist_mem_q[push_idx] <= {acc_ovf_q, acc_s_q};
      end
   end

   assign bus.cmd_ready = (state_q == ST_IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;

   assign add_s_o    = acc_s_q;
   assign add_ovf_o  = acc_ovf_q;
   assign add_x_o    = x_q;
   assign add_y_o    = y_q;
   assign acc_s      = acc_s_q;
   assign acc_ovf    = acc_ovf_q;
   assign hist_count = hist_count_q;

endmodule

// File: doc/dafa_exec_ctrl.md
Name: dafa_exec_ctrl

Overview:
Sequential control stage wrapped around the 12-bit reversible adder (DAFA). It accepts commands over a valid/ready handshake and holds the accumulator (s) and overflow bit. It drives the adder's s/x/y/ovf inputs from registers, waits a fixed settle window, then commits the adder's s/ovf outputs. A LIFO history of prior accumulator states gives reversible undo; the block also checks that the adder returned y unchanged (garbage-free).

Parameters:
WIDTH, 12, datapath width; must match the adder.
DEPTH, 8, history LIFO entries, each {s, ovf}.
SETTLE, 2, cycles the adder inputs are held before commit; minimum 1.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  block can accept; high only in IDLE.
cmd_op  in  2  00 LOAD, 01 ADD, 10 UNDO, 11 CLEAR.
cmd_x  in  WIDTH  x operand (ADD) or load value (LOAD).
cmd_y  in  WIDTH  y operand (ADD).
add_s_o  out  WIDTH  to adder s_in; equals acc_s.
add_x_o  out  WIDTH  to adder x_in; registered x.
add_y_o  out  WIDTH  to adder y_in; registered y.
add_ovf_o  out  1  to adder ovf_in; equals acc_ovf.
add_s_i  in  WIDTH  from adder s_out.
add_y_i  in  WIDTH  from adder y_out.
add_ovf_i  in  1  from adder ovf_out.
acc_s  out  WIDTH  accumulator.
acc_ovf  out  1  overflow flag.
rsp_valid  out  1  one-cycle completion pulse.
rsp_err  out  1  qualifies rsp_valid; 1 = command failed.
hist_count  out  clog2(DEPTH+1)  valid history entries.

Behaviour:
- Reset (async, immediate): acc_s=0, acc_ovf=0, x/y regs=0, hist_count=0, rsp_valid=0, rsp_err=0, state=IDLE, cmd_ready=1. An in-flight ADD is abandoned and produces no response.
- Accept = cmd_valid & cmd_ready at a rising edge (edge E).
- States: IDLE, SETTLE, COMMIT.
- LOAD in IDLE:
  - History full: rsp_err=1, no state change.
  - Otherwise: push {acc_s, acc_ovf}, then acc_s<=cmd_x, acc_ovf<=0.
  - Stays in IDLE. rsp_valid high in the cycle after E.
- UNDO in IDLE:
  - hist_count==0: rsp_err=1, no change.
  - Otherwise: pop top entry into acc_s/acc_ovf.
  - Stays in IDLE. rsp_valid in the cycle after E.
- CLEAR in IDLE: acc_s=0, acc_ovf=0, hist_count=0, rsp_err=0. Stays in IDLE. rsp_valid in the cycle after E.
- ADD:
  - History full at E: rsp_err=1, no change, stays in IDLE.
  - Otherwise at E: x_reg<=cmd_x, y_reg<=cmd_y, counter<=SETTLE-1, state->SETTLE.
  - SETTLE: decrement counter each cycle; go to COMMIT at the edge where counter==0.
  - COMMIT edge:
    - add_y_i==y_reg: push old {acc_s, acc_ovf}, then acc_s<=add_s_i, acc_ovf<=add_ovf_i, rsp_err=0.
    - Otherwise: no accumulator or history change, rsp_err=1.
    - State->IDLE.
  - rsp_valid is high in the cycle following the COMMIT edge, i.e. exactly SETTLE+1 cycles after E.
- cmd_ready=0 in SETTLE/COMMIT. It is 1 again in the same cycle rsp_valid is high, so back-to-back commands are legal.
- cmd_valid while cmd_ready=0 is ignored; the command is not latched.
- rsp_valid is never high for two consecutive cycles from one command. rsp_err is 0 whenever rsp_valid=0.
- LIFO: push writes at index hist_count and increments it; pop reads index hist_count-1 and decrements it. No wrap; an operation that would overflow errors instead.
- Adder outputs and inputs are combinational through the external adder. The block samples add_*_i only at the COMMIT edge.

Test Plan:
- Reset, then ADD x=0x005 y=0x003. Stub adder returns s=s+x, y unchanged. -> rsp_valid 3 cycles after accept (SETTLE=2), rsp_err=0, acc_s=0x005, hist_count=1.
- LOAD 0xFFF, then ADD x=0x001, stub asserts ovf_out=1 and s=0x000. -> acc_s=0x000, acc_ovf=1. UNDO -> acc_s=0xFFF, acc_ovf=0. UNDO -> acc_s=0x005 restored.
- ADD y=0x0A5 with stub returning y_out=0x0A4. -> rsp_err=1, acc_s and hist_count unchanged.
- 8 LOADs fill history; 9th LOAD and an ADD -> rsp_err=1 with no change. 9 UNDOs -> first 8 succeed, 9th rsp_err=1, hist_count=0.
- Assert rst in the SETTLE cycle of an ADD. -> all outputs 0 immediately, no rsp_valid; next command accepted normally.
- Hold cmd_valid high through an ADD with cmd_op=LOAD queued. -> LOAD accepted only in the rsp_valid cycle; its rsp_valid follows one cycle later.
